apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Two-requester APB master that shares a single APB slave (e.g. the memory-register slave) between two internal requesters.
- Arbitrates round-robin and sequences the APB setup/access phases, including PREADY wait states.
- Returns PRDATA/PSLVERR to the granted requester and aborts stalled transfers via a timeout counter.
- Sits between internal masters (CPU port, DMA port) and the APB slave bus.

Parameters:
- DATA_SIZE, 32, data width of PWDATA/PRDATA and requester data.
- ADDR_SIZE, 6, address width of PADDR and requester address.
- TIMEOUT, 16, maximum consecutive ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- reqN_valid  in  1  requester N (N=0,1) has a transfer pending.
- reqN_ready  out  1  requester N transfer accepted this cycle.
- reqN_write  in  1  1=write, 0=read.
- reqN_addr  in  ADDR_SIZE  transfer address.
- reqN_wdata  in  DATA_SIZE  write data.
- reqN_strobe  in  DATA_SIZE/8  write byte lanes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  1  requester index of the completed transfer.
- rsp_rdata  out  DATA_SIZE  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR at completion, or timeout.
- rsp_timeout  out  1  completion caused by timeout.
- PADDR  out  ADDR_SIZE  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_SIZE  APB write data.
- PSTROBE  out  DATA_SIZE/8  APB write strobes.
- PRDATA  in  DATA_SIZE  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (async, PRESETn=0):
  - State goes to IDLE.
  - All registered outputs go to 0, i.e. PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTROBE, and all rsp_* outputs.
  - Round-robin pointer is set so req0 wins the first contention.
  - Wait counter clears.
- All APB and rsp outputs are registered; reqN_ready is combinational.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - grant = the only valid requester; if both are valid, the one not granted last.
  - reqN_ready=1 only for the granted N, only in IDLE.
  - On valid&&ready at the edge, latch write/addr/wdata/strobe and id, update the pointer, and go to SETUP.
  - No request: stay in IDLE, pointer unchanged.
- SETUP (exactly 1 cycle):
  - PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from the latched values.
  - PSTROBE = latched strobe on writes, forced 0 on reads.
  - Go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; address, control and data held stable.
  - PREADY=1 at the edge: complete the transfer.
    - rsp_valid=1 for 1 cycle, rsp_id=latched id.
    - rsp_rdata=PRDATA on reads, 0 on writes.
    - rsp_err=PSLVERR, rsp_timeout=0.
    - PSEL=PENABLE=0, go to IDLE.
  - PREADY=0: increment the wait counter.
  - Timeout: TIMEOUT!=0 and counter reaches TIMEOUT.
    - Complete with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - PSEL/PENABLE drop, go to IDLE.
- Wait counter:
  - Clears on entry to SETUP.
  - Width is clog2(TIMEOUT+1), minimum 1; it saturates and never wraps.
- Latency: acceptance edge → SETUP cycle → ACCESS cycle → rsp_valid in the cycle after the PREADY edge.
  - With no wait states, rsp_valid is high in the 3rd cycle after acceptance.
  - Each PREADY=0 cycle adds 1.
- Transfer spacing: at least one IDLE cycle (PSEL=0) separates consecutive transfers; no back-to-back SETUP.
- Requester rules:
  - A requester may drop valid before ready with no effect.
  - Fields are sampled only at the acceptance edge; later changes are ignored.
- rsp_* outputs other than rsp_valid hold their last value until the next completion.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously, no rsp_valid is generated, and the transfer is lost.
- Simultaneous events:
  - reqN_valid asserting in the same cycle as a completion is not accepted until IDLE.
  - PREADY=1 on the exact timeout cycle is a normal completion (ready has priority).

Test Plan:
- req0 write addr 0x05, wdata 0x55555555, strobe 0xF, PREADY tied 1 → SETUP 1 cycle, ACCESS 1 cycle with PADDR=0x05, PSTROBE=0xF; rsp_valid 3 cycles after acceptance, rsp_id=0, rsp_err=0, rsp_rdata=0.
- req1 read addr 0x2A, PREADY low 2 ACCESS cycles then high with PRDATA=0xDEADBEEF → PENABLE high 3 cycles, PSTROBE=0, rsp_rdata=0xDEADBEEF, rsp_id=1.
- req0 and req1 held valid continuously for 4 transfers → grant order 0,1,0,1; PSEL low ≥1 cycle between transfers.
- Write with PSLVERR=1 at the PREADY edge → rsp_err=1, rsp_timeout=0.
- TIMEOUT=16, PREADY stuck 0 → PENABLE high exactly 16 cycles, then rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0; bus returns to IDLE.
- PRESETn pulsed low during ACCESS, both requesters valid → PSEL=0 immediately, no rsp_valid; after release, req0 is granted first.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master. Requesters 0 and 1 share one APB slave.
// Grants alternate round-robin when both requesters are waiting. Each transfer
// runs one SETUP cycle and then ACCESS cycles until PREADY is seen. A stalled
// ACCESS phase is aborted after TIMEOUT wait cycles; TIMEOUT = 0 disables the abort.
module apb_master_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 6,
  parameter int TIMEOUT   = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_write,
  input  logic [ADDR_SIZE-1:0]   req0_addr,
  input  logic [DATA_SIZE-1:0]   req0_wdata,
  input  logic [DATA_SIZE/8-1:0] req0_strobe,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_write,
  input  logic [ADDR_SIZE-1:0]   req1_addr,
  input  logic [DATA_SIZE-1:0]   req1_wdata,
  input  logic [DATA_SIZE/8-1:0] req1_strobe,
  output logic                   rsp_valid,
  output logic                   rsp_id,
  output logic [DATA_SIZE-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic [ADDR_SIZE-1:0]   PADDR,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [DATA_SIZE-1:0]   PWDATA,
  output logic [DATA_SIZE/8-1:0] PSTROBE,
  input  logic [DATA_SIZE-1:0]   PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  // Counter just wide enough to hold TIMEOUT; at least one bit when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   last_id;
  logic                   grant_id;
  logic                   accept;
  logic                   done_ok;
  logic                   done_to;
  logic                   cur_id;
  logic [CNT_W-1:0]       wait_cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   sel_write;
  logic [ADDR_SIZE-1:0]   sel_addr;
  logic [DATA_SIZE-1:0]   sel_wdata;
  logic [DATA_SIZE/8-1:0] sel_strobe;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_id = req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_id;
    sel_write  = grant_id ? req1_write  : req0_write;
    sel_addr   = grant_id ? req1_addr   : req0_addr;
    sel_wdata  = grant_id ? req1_wdata  : req0_wdata;
    sel_strobe = grant_id ? req1_strobe : req0_strobe;
  end

  // Next-state and handshake decode; PREADY takes priority over the timeout abort.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    cnt_inc    = (wait_cnt == CNT_LIMIT) ? wait_cnt : wait_cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
          done_to   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Round-robin pointer and saturating wait counter; the counter restarts at every acceptance.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      last_id  <= 1'b1;
      wait_cnt <= '0;
    end else if (accept) begin
      last_id  <= grant_id;
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !PREADY) begin
      wait_cnt <= cnt_inc;
    end
  end

  // APB bus outputs: capture the request at acceptance, raise PENABLE after SETUP, drop at completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PSTROBE <= '0;
      cur_id  <= 1'b0;
    end else if (accept) begin
      PSEL    <= 1'b1;
      PENABLE <= 1'b0;
      PWRITE  <= sel_write;
      PADDR   <= sel_addr;
      PWDATA  <= sel_wdata;
      PSTROBE <= sel_write ? sel_strobe : '0;
      cur_id  <= grant_id;
    end else if (state == SETUP) begin
      PENABLE <= 1'b1;
    end else if (done_ok || done_to) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end
  end

  // Completion response: one-cycle valid pulse; the other fields hold until the next completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= done_ok || done_to;
      if (done_ok || done_to) begin
        rsp_id      <= cur_id;
        rsp_rdata   <= (done_ok && !PWRITE) ? PRDATA : '0;
        rsp_err     <= done_ok ? PSLVERR : 1'b1;
        rsp_timeout <= done_to;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter. A reference model predicts the
// grants and ready signals. At each acceptance the bench pushes two entries:
// the slave plan (wait states, read data, error) and the expected response.
// An APB slave process drives the bus from the plan queue. A monitor process
// pops the expected response and compares it with the DUT response.
module tb_apb_master_arbiter;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_write;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic [SW-1:0] req0_strobe;
  logic          req1_valid, req1_ready, req1_write;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic [SW-1:0] req1_strobe;
  logic          rsp_valid, rsp_id, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTROBE;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int          waits;
    logic [DW-1:0] prdata;
    bit          err;
    int          access;
  } plan_t;

  typedef struct {
    int          id;
    logic [DW-1:0] rdata;
    bit          err;
    bit          to;
    int          cyc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    grant_log[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy  = 0;
  int last_gnt = 1;
  bit acc0, acc1;
  int            nxt_waits;
  logic [DW-1:0] nxt_prdata;
  bit            nxt_err;

  apb_master_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
    .PCLK(clk), .PRESETn(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_strobe(req0_strobe),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_strobe(req1_strobe),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTROBE(PSTROBE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_fields(input int id, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
    if (id == 0) begin
      req0_write = wr; req0_addr = a; req0_wdata = d; req0_strobe = s;
    end else begin
      req1_write = wr; req1_addr = a; req1_wdata = d; req1_strobe = s;
    end
  endtask

  task automatic rand_fields(input int id);
    set_fields(id, 1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom));
  endtask

  // Slave plan for whichever transfer is accepted next.
  task automatic rand_plan();
    int r;
    r = $urandom_range(0, 15);
    if (r < 10)      nxt_waits = r % 3;
    else if (r < 12) nxt_waits = TO - 1;
    else if (r < 14) nxt_waits = TO;
    else             nxt_waits = $urandom_range(4, 8);
    nxt_prdata = DW'($urandom);
    nxt_err    = ($urandom_range(0, 3) == 0);
  endtask

  // Called right after a falling edge: check ready against the model, then record any acceptance.
  task automatic step();
    bit    any, exp_r0, exp_r1, tmo;
    int    gid;
    plan_t p;
    exp_t  e;
    #1;
    any = req0_valid || req1_valid;
    if (req0_valid && req1_valid) gid = (last_gnt == 1) ? 0 : 1;
    else                          gid = req1_valid ? 1 : 0;
    exp_r0 = (busy == 0) && any && (gid == 0);
    exp_r1 = (busy == 0) && any && (gid == 1);
    chk("req0_ready", 64'(req0_ready), 64'(exp_r0));
    chk("req1_ready", 64'(req1_ready), 64'(exp_r1));
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (busy > 0) begin
      busy--;
    end else if (any) begin
      if (gid == 0) begin
        p.wr = req0_write; p.addr = req0_addr; p.wdata = req0_wdata; p.strb = req0_strobe; acc0 = 1'b1;
      end else begin
        p.wr = req1_write; p.addr = req1_addr; p.wdata = req1_wdata; p.strb = req1_strobe; acc1 = 1'b1;
      end
      tmo      = (TO != 0) && (nxt_waits >= TO);
      p.waits  = nxt_waits;
      p.prdata = nxt_prdata;
      p.err    = nxt_err;
      p.access = tmo ? TO : nxt_waits + 1;
      e.id     = gid;
      e.to     = tmo;
      e.err    = tmo ? 1'b1 : nxt_err;
      e.rdata  = (tmo || p.wr) ? '0 : nxt_prdata;
      e.cyc    = cyc + 1 + p.access + 1;
      plan_q.push_back(p);
      exp_q.push_back(e);
      grant_log.push_back(gid);
      last_gnt = gid;
      busy     = p.access + 1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy > 0 && n < 60) begin
      step();
      n++;
    end
    chk("drain_idle", 64'(busy), 64'(0));
    step();
    step();
  endtask

  task automatic directed(input int id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input int waits, input logic [DW-1:0] prd, input bit err);
    int n;
    nxt_waits = waits; nxt_prdata = prd; nxt_err = err;
    set_fields(id, wr, a, d, s);
    req0_valid = (id == 0);
    req1_valid = (id == 1);
    n = 0;
    do begin
      step();
      n++;
    end while (!(acc0 || acc1) && n < 20);
    chk("directed_accept", 64'(acc0 || acc1), 64'(1));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rand_fields(0);
    rand_fields(1);
    drain();
  endtask

  task automatic rand_req(input int id, input bit acc);
    bit oldv, newv, refresh;
    oldv = (id == 0) ? req0_valid : req1_valid;
    if (acc)       newv = 1'($urandom_range(0, 1));
    else if (oldv) newv = ($urandom_range(0, 7) != 0);
    else           newv = ($urandom_range(0, 2) == 0);
    refresh = acc || !oldv || ($urandom_range(0, 1) == 1);
    if (refresh) rand_fields(id);
    if (id == 0) req0_valid = newv;
    else         req1_valid = newv;
  endtask

  // APB slave: follows the plan queue, checks bus fields and the number of ACCESS cycles.
  initial begin
    plan_t cur;
    bit    have, prev_acc;
    int    waits_left, acc_cnt;
    have = 1'b0; prev_acc = 1'b0; waits_left = 0; acc_cnt = 0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 1'b0; prev_acc = 1'b0; PREADY = 1'b0;
      end else begin
        if (PSEL && !PENABLE) begin
          chk("setup_spacing", 64'(prev_acc), 64'(0));
          if (plan_q.size() == 0) begin
            total++; bad++;
            $display("FAIL setup_unexpected: got SETUP addr 0x%0h, want no transfer", PADDR);
            have = 1'b0;
          end else begin
            cur = plan_q.pop_front();
            have = 1'b1;
            waits_left = cur.waits;
            acc_cnt = 0;
            chk("setup_ctrl", {PADDR, PWRITE, PSTROBE}, {cur.addr, cur.wr, cur.wr ? cur.strb : SW'(0)});
            chk("setup_wdata", 64'(PWDATA), 64'(cur.wdata));
          end
          PREADY = 1'($urandom); PRDATA = DW'($urandom); PSLVERR = 1'($urandom);
        end else if (PSEL && PENABLE) begin
          acc_cnt++;
          if (have) begin
            chk("access_ctrl", {PADDR, PWRITE, PSTROBE}, {cur.addr, cur.wr, cur.wr ? cur.strb : SW'(0)});
            chk("access_wdata", 64'(PWDATA), 64'(cur.wdata));
          end
          if (waits_left > 0) begin
            waits_left--;
            PREADY = 1'b0; PRDATA = DW'($urandom); PSLVERR = 1'($urandom);
          end else begin
            PREADY = 1'b1; PRDATA = cur.prdata; PSLVERR = cur.err;
          end
        end else begin
          if (have) begin
            chk("access_cycles", 64'(acc_cnt), 64'(cur.access));
            have = 1'b0;
          end
          PREADY = 1'($urandom); PRDATA = DW'($urandom); PSLVERR = 1'($urandom);
        end
        prev_acc = PSEL && PENABLE;
      end
    end
  end

  // Response monitor: pops the scoreboard on each completion and checks held values otherwise.
  initial begin
    exp_t          e;
    logic          h_id, h_err, h_to;
    logic [DW-1:0] h_rdata;
    h_id = 1'b0; h_err = 1'b0; h_to = 1'b0; h_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        h_id = 1'b0; h_err = 1'b0; h_to = 1'b0; h_rdata = '0;
      end else if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d, want no response", rsp_id);
          h_id = rsp_id; h_err = rsp_err; h_to = rsp_timeout; h_rdata = rsp_rdata;
        end else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
          h_id = 1'(e.id); h_err = e.err; h_to = e.to; h_rdata = e.rdata;
        end
      end else begin
        chk("rsp_hold", {rsp_id, rsp_err, rsp_timeout, rsp_rdata}, {h_id, h_err, h_to, h_rdata});
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    set_fields(0, 1'b0, '0, '0, '0);
    set_fields(1, 1'b0, '0, '0, '0);
    nxt_waits = 0; nxt_prdata = '0; nxt_err = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_psel", 64'(PSEL), 64'(0));
    chk("rst_penable", 64'(PENABLE), 64'(0));
    chk("rst_pwrite", 64'(PWRITE), 64'(0));
    chk("rst_paddr", 64'(PADDR), 64'(0));
    chk("rst_pwdata", 64'(PWDATA), 64'(0));
    chk("rst_pstrobe", 64'(PSTROBE), 64'(0));
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_timeout, rsp_rdata}, 64'(0));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed transfers: plain write, read with waits, slave error, timeout, ready on the last allowed cycle.
    directed(0, 1'b1, 6'h05, 32'h55555555, 4'hF, 0, 32'h0, 1'b0);
    directed(1, 1'b0, 6'h2A, 32'h0, 4'hF, 2, 32'hDEADBEEF, 1'b0);
    directed(0, 1'b1, 6'h11, 32'hA5A50F0F, 4'h3, 1, 32'h0, 1'b1);
    directed(1, 1'b0, 6'h3C, 32'h0, 4'h0, TO, 32'hCAFEF00D, 1'b0);
    directed(0, 1'b0, 6'h07, 32'h0, 4'h0, TO - 1, 32'h12345678, 1'b1);
    directed(1, 1'b1, 6'h3F, 32'h01020304, 4'hC, 40, 32'h0, 1'b0);

    // Reset in the middle of an ACCESS phase with both requesters pending.
    nxt_waits = 10; nxt_prdata = 32'h0BADF00D; nxt_err = 1'b0;
    set_fields(1, 1'b0, 6'h15, 32'h0, 4'h0);
    req1_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc1 && n < 20);
    chk("mid_accept", 64'(acc1), 64'(1));
    req1_valid = 1'b0;
    step();
    step();
    rand_fields(0);
    rand_fields(1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", 64'(PSEL), 64'(0));
    chk("mid_rst_penable", 64'(PENABLE), 64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    plan_q.delete();
    exp_q.delete();
    grant_log.delete();
    busy = 0;
    last_gnt = 1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));

    // Both requesters held valid: grants must alternate starting with requester 0.
    n = 0;
    while (grant_log.size() < 4 && n < 200) begin
      nxt_waits = $urandom_range(0, 2); nxt_prdata = DW'($urandom); nxt_err = 1'b0;
      if (acc0) rand_fields(0);
      if (acc1) rand_fields(1);
      step();
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
    chk("rr_count", 64'(grant_log.size() >= 4), 64'(1));
    for (int i = 0; i < grant_log.size() && i < 4; i++) chk("rr_order", 64'(grant_log[i]), 64'(i % 2));

    // Random traffic.
    for (int c = 0; c < 2500; c++) begin
      rand_plan();
      rand_req(0, acc0);
      rand_req(1, acc1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    chk("plan_empty", 64'(plan_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
